// File: rtl/sat_window_stats.sv
// Windowed sum / max / overflow-count collector with a single-entry valid/ready result register.
// Max tracking is built only when SAT_STATS_MAX_EN is defined; otherwise res_max is tied to 0.
module sat_window_stats #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned WINDOW = 8,
   parameter int unsigned CNT_W  = $clog2(WINDOW + 1),
   parameter int unsigned SUM_W  = DATA_W + $clog2(WINDOW)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_ovf,
   input  logic              flush,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [SUM_W-1:0]  res_sum,
   output logic [DATA_W-1:0] res_max,
   output logic [CNT_W-1:0]  res_ovf_cnt,
   output logic [CNT_W-1:0]  res_cnt,
   output logic              drop
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t            state_q, state_d;
   logic [SUM_W-1:0]  acc_sum_q, acc_sum_d, win_sum;
   logic [CNT_W-1:0]  acc_ovf_q, acc_ovf_d, win_ovf;
   logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d, win_cnt;
   logic [SUM_W-1:0]  res_sum_q, res_sum_d;
   logic [CNT_W-1:0]  res_ovf_q, res_ovf_d;
   logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
   logic              drop_q, drop_d;
   logic              close;
   logic              load;

   // win_* are the window totals including the sample arriving this cycle.
   always_comb begin
      win_sum = acc_sum_q;
      win_ovf = acc_ovf_q;
      win_cnt = acc_cnt_q;
      if (in_valid) begin
         win_sum = acc_sum_q + SUM_W'(in_data);
         win_ovf = acc_ovf_q + CNT_W'(in_ovf);
         win_cnt = acc_cnt_q + CNT_W'(1);
      end
      close = (in_valid && (win_cnt == CNT_W'(WINDOW))) || (flush && (win_cnt != '0));
      load  = close && ((state_q == EMPTY) || res_ready);

      acc_sum_d = close ? '0 : win_sum;
      acc_ovf_d = close ? '0 : win_ovf;
      acc_cnt_d = close ? '0 : win_cnt;

      res_sum_d = load ? win_sum : res_sum_q;
      res_ovf_d = load ? win_ovf : res_ovf_q;
      res_cnt_d = load ? win_cnt : res_cnt_q;
      drop_d    = close && !load;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= EMPTY;
         acc_sum_q <= '0;
         acc_ovf_q <= '0;
         acc_cnt_q <= '0;
         res_sum_q <= '0;
         res_ovf_q <= '0;
         res_cnt_q <= '0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_sum_q <= acc_sum_d;
         acc_ovf_q <= acc_ovf_d;
         acc_cnt_q <= acc_cnt_d;
         res_sum_q <= res_sum_d;
         res_ovf_q <= res_ovf_d;
         res_cnt_q <= res_cnt_d;
         drop_q    <= drop_d;
      end
   end

   // A close while FULL keeps FULL whether it was a handover or a drop.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (close) state_d = FULL;
         FULL:    if (!close && res_ready) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      res_valid   = (state_q == FULL);
      res_sum     = res_sum_q;
      res_ovf_cnt = res_ovf_q;
      res_cnt     = res_cnt_q;
      drop        = drop_q;
   end

`ifdef SAT_STATS_MAX_EN
   logic [DATA_W-1:0] acc_max_q, acc_max_d, win_max;
   logic [DATA_W-1:0] res_max_q, res_max_d;

   always_comb begin
      win_max   = (in_valid && (in_data > acc_max_q)) ? in_data : acc_max_q;
      acc_max_d = close ? '0 : win_max;
      res_max_d = load ? win_max : res_max_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_max_q <= '0;
         res_max_q <= '0;
      end else begin
         acc_max_q <= acc_max_d;
         res_max_q <= res_max_d;
      end
   end

   assign res_max = res_max_q;
`else
   assign res_max = '0;
`endif

endmodule

// File: tb/tb_sat_window_stats.sv
// Self-checking bench for sat_window_stats (DATA_W=4, WINDOW=4): directed scenarios plus
// randomized traffic against a queue-based window model.
module tb_sat_window_stats;

   localparam int DW  = 4;
   localparam int WIN = 4;
   localparam int CW  = 3;
   localparam int SW  = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ovf = 1'b0;
   logic          flush = 1'b0;
   logic          res_ready = 1'b0;
   logic          res_valid;
   logic [SW-1:0] res_sum;
   logic [DW-1:0] res_max;
   logic [CW-1:0] res_ovf_cnt;
   logic [CW-1:0] res_cnt;
   logic          drop;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the open window as a list of samples, plus the result register contents.
   int q_data[$];
   int q_ovf[$];
   bit m_valid;
   bit m_drop;
   int m_sum, m_max, m_ovf, m_cnt;

   always #5 clk = ~clk;

   sat_window_stats #(
      .DATA_W(DW),
      .WINDOW(WIN)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ovf(in_ovf),
      .flush(flush),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_sum(res_sum),
      .res_max(res_max),
      .res_ovf_cnt(res_ovf_cnt),
      .res_cnt(res_cnt),
      .drop(drop)
   );

   function automatic int exp_max(input int v);
`ifdef SAT_STATS_MAX_EN
      return v;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      q_data.delete();
      q_ovf.delete();
      m_valid = 0;
      m_drop  = 0;
      m_sum   = 0;
      m_max   = 0;
      m_ovf   = 0;
      m_cnt   = 0;
   endtask

   task automatic model_step();
      bit close;
      int s, mx, ov;
      if (in_valid) begin
         q_data.push_back(int'(in_data));
         q_ovf.push_back(int'(in_ovf));
      end
      close  = (q_data.size() == WIN) || (flush && q_data.size() >= 1);
      m_drop = 0;
      if (close) begin
         s = 0; mx = 0; ov = 0;
         foreach (q_data[i]) begin
            s  += q_data[i];
            ov += q_ovf[i];
            if (q_data[i] > mx) mx = q_data[i];
         end
         if (!m_valid || res_ready) begin
            m_valid = 1;
            m_sum   = s;
            m_max   = exp_max(mx);
            m_ovf   = ov;
            m_cnt   = q_data.size();
         end else begin
            m_drop = 1;
         end
         q_data.delete();
         q_ovf.delete();
      end else if (m_valid && res_ready) begin
         m_valid = 0;
      end
   endtask

   task automatic cycle(input bit v, input int d, input bit o, input bit f, input bit r);
      in_valid  = v;
      in_data   = DW'(d);
      in_ovf    = o;
      flush     = f;
      res_ready = r;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      int d[4] = '{1, 2, 3, 4};
      #3;
      n_tests++;
      if (res_valid !== 1'b0 || res_sum !== '0 || res_cnt !== '0 || drop !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_initial: valid=%b sum=%0d cnt=%0d drop=%b, required all 0",
                  res_valid, res_sum, res_cnt, drop);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) cycle(1, 5, 0, 0, 0);
      cycle(1, 3, 1, 0, 0);
      cycle(1, 3, 1, 0, 0);
      n_tests++;
      if (res_valid !== 1'b1 || res_sum !== SW'(20)) begin
         n_fail++;
         $display("FAIL reset_pending_setup: valid=%b sum=%0d, required 1/20", res_valid, res_sum);
      end
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      n_tests++;
      if (res_valid !== 1'b0 || res_sum !== '0 || res_max !== '0 || res_ovf_cnt !== '0 ||
          res_cnt !== '0 || drop !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_midstream: valid=%b sum=%0d max=%0d ovf=%0d cnt=%0d drop=%b, required all 0",
                  res_valid, res_sum, res_max, res_ovf_cnt, res_cnt, drop);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) cycle(1, d[i], 0, 0, 0);
      n_tests++;
      if (res_valid !== 1'b1 || res_sum !== SW'(10) || res_cnt !== CW'(4) ||
          res_ovf_cnt !== CW'(0) || res_max !== DW'(exp_max(4))) begin
         n_fail++;
         $display("FAIL reset_first_result: valid=%b sum=%0d cnt=%0d ovf=%0d max=%0d, required 1/10/4/0/%0d",
                  res_valid, res_sum, res_cnt, res_ovf_cnt, res_max, exp_max(4));
      end
   endtask

   task automatic test_basic_window();
      int d[4] = '{3, 8, 8, 5};
      int o[4] = '{0, 1, 1, 0};
      for (int i = 0; i < 4; i++) cycle(1, d[i], o[i] != 0, 0, 1);
      n_tests++;
      if (res_valid !== 1'b1 || res_sum !== SW'(24) || res_max !== DW'(exp_max(8)) ||
          res_ovf_cnt !== CW'(2) || res_cnt !== CW'(4)) begin
         n_fail++;
         $display("FAIL basic_window: valid=%b sum=%0d max=%0d ovf=%0d cnt=%0d, required 1/24/%0d/2/4",
                  res_valid, res_sum, res_max, res_ovf_cnt, res_cnt, exp_max(8));
      end
      cycle(0, 0, 0, 0, 1);
      n_tests++;
      if (res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_consumed: valid=%b, required 0", res_valid);
      end
   endtask

   task automatic test_backpressure_drop();
      for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);
      n_tests++;
      if (res_valid !== 1'b1 || res_sum !== SW'(4) || drop !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_first: valid=%b sum=%0d drop=%b, required 1/4/0", res_valid, res_sum, drop);
      end
      for (int i = 0; i < 4; i++) cycle(1, 2, 0, 0, 0);
      n_tests++;
      if (drop !== 1'b1 || res_valid !== 1'b1 || res_sum !== SW'(4)) begin
         n_fail++;
         $display("FAIL bp_drop: drop=%b valid=%b sum=%0d, required 1/1/4", drop, res_valid, res_sum);
      end
      cycle(0, 0, 0, 0, 0);
      n_tests++;
      if (drop !== 1'b0 || res_valid !== 1'b1 || res_sum !== SW'(4)) begin
         n_fail++;
         $display("FAIL bp_hold: drop=%b valid=%b sum=%0d, required 0/1/4", drop, res_valid, res_sum);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) cycle(1, 2, 0, 0, 0);
      cycle(1, 2, 0, 0, 1);
      n_tests++;
      if (res_valid !== 1'b1 || res_sum !== SW'(8) || drop !== 1'b0) begin
         n_fail++;
         $display("FAIL handover: valid=%b sum=%0d drop=%b, required 1/8/0", res_valid, res_sum, drop);
      end
      cycle(0, 0, 0, 0, 1);
      n_tests++;
      if (res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL handover_consumed: valid=%b, required 0", res_valid);
      end
   endtask

   task automatic test_flush();
      cycle(1, 7, 0, 0, 1);
      cycle(1, 2, 0, 0, 1);
      cycle(0, 0, 0, 1, 1);
      n_tests++;
      if (res_valid !== 1'b1 || res_sum !== SW'(9) || res_max !== DW'(exp_max(7)) ||
          res_cnt !== CW'(2) || res_ovf_cnt !== CW'(0)) begin
         n_fail++;
         $display("FAIL flush_partial: valid=%b sum=%0d max=%0d cnt=%0d ovf=%0d, required 1/9/%0d/2/0",
                  res_valid, res_sum, res_max, res_cnt, res_ovf_cnt, exp_max(7));
      end
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 1, 1);
      n_tests++;
      if (res_valid !== 1'b0 || drop !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_empty: valid=%b drop=%b, required 0/0", res_valid, drop);
      end
      cycle(1, 1, 0, 0, 0);
      cycle(1, 2, 0, 0, 0);
      cycle(1, 3, 0, 0, 0);
      cycle(1, 4, 1, 1, 0);
      n_tests++;
      if (res_valid !== 1'b1 || res_cnt !== CW'(4) || res_sum !== SW'(10) || res_ovf_cnt !== CW'(1)) begin
         n_fail++;
         $display("FAIL flush_full: valid=%b cnt=%0d sum=%0d ovf=%0d, required 1/4/10/1",
                  res_valid, res_cnt, res_sum, res_ovf_cnt);
      end
      cycle(0, 0, 0, 0, 1);
      n_tests++;
      if (res_valid !== 1'b0 || drop !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_single_close: valid=%b drop=%b, required 0/0", res_valid, drop);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
         n_tests++;
         if (res_valid !== m_valid || drop !== m_drop || res_sum !== SW'(m_sum) ||
             res_max !== DW'(m_max) || res_ovf_cnt !== CW'(m_ovf) || res_cnt !== CW'(m_cnt)) begin
            n_fail++;
            $display("FAIL random[%0d]: got v=%b d=%b s=%0d m=%0d o=%0d c=%0d, required v=%b d=%b s=%0d m=%0d o=%0d c=%0d",
                     i, res_valid, drop, res_sum, res_max, res_ovf_cnt, res_cnt,
                     m_valid, m_drop, m_sum, m_max, m_ovf, m_cnt);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic_window();
      test_backpressure_drop();
      test_back_to_back();
      test_flush();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
